uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter between NUM_REQ AXI-Stream byte sources.

---
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter AXIS sink among NUM_REQ AXIS byte
// sources with packet-granular round-robin arbitration and a registered master stage.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_s_axis_tvalid,
    input  logic [8*NUM_REQ-1:0]       i_s_axis_tdata,
    input  logic [NUM_REQ-1:0]         i_s_axis_tlast,
    output logic [NUM_REQ-1:0]         o_s_axis_tready,
    output logic                       o_m_axis_tvalid,
    output logic [7:0]                 o_m_axis_tdata,
    output logic                       o_m_axis_tlast,
    input  logic                       i_m_axis_tready,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic                       o_busy
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [CW-1:0] BURST_LAST = (MAX_BURST > 0) ? CW'(MAX_BURST - 1) : '0;
    localparam logic [GW-1:0] LAST_ID    = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_r,    state_s;
    logic [GW-1:0]   rr_ptr_r,   rr_ptr_s;
    logic [GW-1:0]   grant_r,    grant_s;
    logic [CW-1:0]   byte_cnt_r, byte_cnt_s;
    logic            m_tvalid_r, m_tvalid_s;
    logic [7:0]      m_tdata_r,  m_tdata_s;
    logic            m_tlast_r,  m_tlast_s;
    logic            busy_r;
    logic [NUM_REQ-1:0] s_ready_s;

    logic            out_free_s;
    logic            sel_valid_s;
    logic [7:0]      sel_data_s;
    logic            sel_last_s;
    logic            burst_end_s;
    logic [GW-1:0]   next_id_s;

    // First requester with valid set, scanning upward from ptr with wrap.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [GW-1:0]      ptr);
        logic [GW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    assign out_free_s  = !m_tvalid_r || i_m_axis_tready;
    assign sel_valid_s = i_s_axis_tvalid[grant_r];
    assign sel_data_s  = i_s_axis_tdata[{grant_r, 3'b000} +: 8];
    assign sel_last_s  = i_s_axis_tlast[grant_r];
    assign burst_end_s = (MAX_BURST != 0) && (byte_cnt_r == BURST_LAST);
    assign next_id_s   = (grant_r == LAST_ID) ? GW'(0) : grant_r + GW'(1);

    // Next-state, slave ready and output-register load logic.
    always_comb begin
        state_s    = state_r;
        rr_ptr_s   = rr_ptr_r;
        grant_s    = grant_r;
        byte_cnt_s = byte_cnt_r;
        s_ready_s  = '0;
        m_tvalid_s = m_tvalid_r && !i_m_axis_tready;
        m_tdata_s  = m_tdata_r;
        m_tlast_s  = m_tlast_r;
        case (state_r)
            ST_IDLE: begin
                if (|i_s_axis_tvalid) begin
                    grant_s    = rr_pick(i_s_axis_tvalid, rr_ptr_r);
                    byte_cnt_s = '0;
                    state_s    = ST_XFER;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                s_ready_s[grant_r] = out_free_s;
                if (sel_valid_s && out_free_s) begin
                    m_tvalid_s = 1'b1;
                    m_tdata_s  = sel_data_s;
                    m_tlast_s  = sel_last_s || burst_end_s;
                    byte_cnt_s = byte_cnt_r + CW'(1);
                    if (sel_last_s || burst_end_s) begin
                        rr_ptr_s = next_id_s;
                        state_s  = ST_DRAIN;
                    end else begin
                        state_s = ST_XFER;
                    end
                end else begin
                    state_s = ST_XFER;
                end
            end
            ST_DRAIN: begin
                if (out_free_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, arbitration and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            grant_r    <= '0;
            byte_cnt_r <= '0;
            m_tvalid_r <= 1'b0;
            m_tdata_r  <= 8'h00;
            m_tlast_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            rr_ptr_r   <= rr_ptr_s;
            grant_r    <= grant_s;
            byte_cnt_r <= byte_cnt_s;
            m_tvalid_r <= m_tvalid_s;
            m_tdata_r  <= m_tdata_s;
            m_tlast_r  <= m_tlast_s;
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    assign o_s_axis_tready = s_ready_s;
    assign o_m_axis_tvalid = m_tvalid_r;
    assign o_m_axis_tdata  = m_tdata_r;
    assign o_m_axis_tlast  = m_tlast_r;
    assign o_grant_id      = grant_r;
    assign o_busy          = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one unlimited-burst instance and one MAX_BURST=2
// instance share a small per-requester byte-source model and a master-side byte log.
module tb_uart_tx_arbiter;
    logic        clk;
    logic        rst_n;
    logic [3:0]  sv;
    logic [31:0] sd;
    logic [3:0]  sl;
    logic        m_ready;
    logic        active;

    logic [3:0]  sv0, sv1;
    logic [3:0]  rdy0, rdy1;
    logic        mv0, mv1, ml0, ml1, busy0, busy1;
    logic [7:0]  md0, md1;
    logic [1:0]  gid0, gid1;

    logic [3:0]  s_ready;
    logic        m_valid, m_last, busy;
    logic [7:0]  m_data;
    logic [1:0]  grant;

    logic [7:0]  src_data [4][8];
    logic        src_last [4][8];
    int          src_len  [4];
    int          src_idx  [4];
    logic        src_en   [4];

    logic [10:0] log_q[$];
    logic [10:0] exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    assign sv0 = active ? 4'b0000 : sv;
    assign sv1 = active ? sv : 4'b0000;
    assign s_ready = active ? rdy1  : rdy0;
    assign m_valid = active ? mv1   : mv0;
    assign m_data  = active ? md1   : md0;
    assign m_last  = active ? ml1   : ml0;
    assign grant   = active ? gid1  : gid0;
    assign busy    = active ? busy1 : busy0;

    uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_s_axis_tvalid(sv0), .i_s_axis_tdata(sd), .i_s_axis_tlast(sl),
        .o_s_axis_tready(rdy0),
        .o_m_axis_tvalid(mv0), .o_m_axis_tdata(md0), .o_m_axis_tlast(ml0),
        .i_m_axis_tready(m_ready), .o_grant_id(gid0), .o_busy(busy0)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(2)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_s_axis_tvalid(sv1), .i_s_axis_tdata(sd), .i_s_axis_tlast(sl),
        .o_s_axis_tready(rdy1),
        .o_m_axis_tvalid(mv1), .o_m_axis_tdata(md1), .o_m_axis_tlast(ml1),
        .i_m_axis_tready(m_ready), .o_grant_id(gid1), .o_busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] e(input logic [1:0] g, input logic l, input logic [7:0] d);
        return {g, l, d};
    endfunction

    task automatic clear_src();
        for (int k = 0; k < 4; k++) begin
            src_len[k] = 0;
            src_idx[k] = 0;
            src_en[k]  = 1'b1;
        end
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic add(input int k, input logic [7:0] d, input logic l);
        src_data[k][src_len[k]] = d;
        src_last[k][src_len[k]] = l;
        src_len[k]++;
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            if (src_idx[k] < src_len[k]) begin
                sv[k]        = src_en[k];
                sd[8*k +: 8] = src_data[k][src_idx[k]];
                sl[k]        = src_last[k][src_idx[k]];
            end else begin
                sv[k]        = 1'b0;
                sd[8*k +: 8] = 8'h00;
                sl[k]        = 1'b0;
            end
        end
    endtask

    // One clock: sample handshakes on the falling edge, advance sources after the rising edge.
    task automatic cyc();
        logic [3:0] hs;
        @(negedge clk);
        hs = sv & s_ready;
        chk("ready_onehot", 32'($countones(s_ready) <= 1), 32'd1);
        if (m_valid && m_ready) log_q.push_back({grant, m_last, m_data});
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (hs[k]) src_idx[k]++;
        end
        drive();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_data"},  32'(m_data),  32'd0);
        chk({tag, "_m_last"},  32'(m_last),  32'd0);
        chk({tag, "_grant"},   32'(grant),   32'd0);
        chk({tag, "_busy"},    32'(busy),    32'd0);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; m_ready = 1'b1; active = 1'b0;
        sv = 4'b0000; sd = 32'h0; sl = 4'b0000;
        clear_src(); drive();
        cyc(); cyc();
        check_zero("reset");
        rst_n = 1'b1;
        cyc();

        // 3-byte packet from req0, cycle by cycle
        clear_src();
        add(0, 8'h01, 1'b0); add(0, 8'h02, 1'b0); add(0, 8'h03, 1'b1);
        drive();
        cyc();
        chk("t1_arb_busy", 32'(busy), 32'd1);
        chk("t1_arb_grant", 32'(grant), 32'd0);
        chk("t1_arb_ready", 32'(s_ready), 32'h1);
        chk("t1_arb_mvalid", 32'(m_valid), 32'd0);
        cyc();
        chk("t1_b0_mvalid", 32'(m_valid), 32'd1);
        chk("t1_b0_data", 32'(m_data), 32'h01);
        chk("t1_b0_last", 32'(m_last), 32'd0);
        cyc(); cyc();
        chk("t1_b2_data", 32'(m_data), 32'h03);
        chk("t1_b2_last", 32'(m_last), 32'd1);
        chk("t1_drain_busy", 32'(busy), 32'd1);
        chk("t1_drain_ready", 32'(s_ready), 32'h0);
        cyc();
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_mvalid", 32'(m_valid), 32'd0);
        chk("t1_idle_grant", 32'(grant), 32'd0);
        exp_q.push_back(e(2'd0, 1'b0, 8'h01));
        exp_q.push_back(e(2'd0, 1'b0, 8'h02));
        exp_q.push_back(e(2'd0, 1'b1, 8'h03));
        check_log("t1_log");

        // rr pointer now at 1: req1 wins over req0
        clear_src();
        add(0, 8'h11, 1'b1); add(1, 8'h21, 1'b1);
        drive(); run(10);
        exp_q.push_back(e(2'd1, 1'b1, 8'h21));
        exp_q.push_back(e(2'd0, 1'b1, 8'h11));
        check_log("t1_rr_log");

        // all requesters valid from reset
        rst_n = 1'b0;
        clear_src();
        add(0, 8'hA0, 1'b1); add(1, 8'hB1, 1'b1); add(2, 8'hC2, 1'b1);
        add(3, 8'hD3, 1'b1); add(0, 8'hA4, 1'b1);
        drive(); cyc();
        rst_n = 1'b1;
        run(30);
        exp_q.push_back(e(2'd0, 1'b1, 8'hA0));
        exp_q.push_back(e(2'd1, 1'b1, 8'hB1));
        exp_q.push_back(e(2'd2, 1'b1, 8'hC2));
        exp_q.push_back(e(2'd3, 1'b1, 8'hD3));
        exp_q.push_back(e(2'd0, 1'b1, 8'hA4));
        check_log("t2_log");

        // back-pressure from uart_tx for 20 cycles
        clear_src();
        add(1, 8'h31, 1'b0); add(1, 8'h32, 1'b0); add(1, 8'h33, 1'b1);
        m_ready = 1'b0;
        drive(); cyc(); cyc();
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("t3_hold_mvalid", 32'(m_valid), 32'd1);
            chk("t3_hold_data", 32'(m_data), 32'h31);
            chk("t3_hold_ready", 32'(s_ready), 32'h0);
        end
        m_ready = 1'b1;
        run(10);
        exp_q.push_back(e(2'd1, 1'b0, 8'h31));
        exp_q.push_back(e(2'd1, 1'b0, 8'h32));
        exp_q.push_back(e(2'd1, 1'b1, 8'h33));
        check_log("t3_log");

        // MAX_BURST=2 instance: req2 split into bursts around req3's packet
        active = 1'b1;
        clear_src();
        add(2, 8'h41, 1'b0); add(2, 8'h42, 1'b0); add(2, 8'h43, 1'b0);
        add(2, 8'h44, 1'b0); add(2, 8'h45, 1'b1);
        add(3, 8'h51, 1'b0); add(3, 8'h52, 1'b1);
        drive(); run(40);
        exp_q.push_back(e(2'd2, 1'b0, 8'h41));
        exp_q.push_back(e(2'd2, 1'b1, 8'h42));
        exp_q.push_back(e(2'd3, 1'b0, 8'h51));
        exp_q.push_back(e(2'd3, 1'b1, 8'h52));
        exp_q.push_back(e(2'd2, 1'b0, 8'h43));
        exp_q.push_back(e(2'd2, 1'b1, 8'h44));
        exp_q.push_back(e(2'd2, 1'b1, 8'h45));
        check_log("t4_log");
        active = 1'b0;
        clear_src(); drive();

        // reset while a byte is held in the output register
        add(2, 8'h91, 1'b0); add(2, 8'h92, 1'b0); add(2, 8'h93, 1'b1);
        m_ready = 1'b0;
        drive(); cyc(); cyc();
        chk("t5_pre_mvalid", 32'(m_valid), 32'd1);
        chk("t5_pre_grant", 32'(grant), 32'd2);
        rst_n = 1'b0;
        clear_src(); drive(); cyc();
        check_zero("t5_rst");
        rst_n = 1'b1;
        m_ready = 1'b1;
        add(0, 8'h61, 1'b0); add(0, 8'h62, 1'b1);
        drive(); run(12);
        exp_q.push_back(e(2'd0, 1'b0, 8'h61));
        exp_q.push_back(e(2'd0, 1'b1, 8'h62));
        check_log("t5_log");

        // granted source stalls mid-packet while req3 waits
        clear_src();
        add(1, 8'h71, 1'b0); add(1, 8'h72, 1'b0); add(1, 8'h73, 1'b0); add(1, 8'h74, 1'b1);
        add(3, 8'h81, 1'b1);
        drive(); cyc(); cyc();
        src_en[1] = 1'b0;
        drive();
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("t6_stall_grant", 32'(grant), 32'd1);
            chk("t6_stall_busy", 32'(busy), 32'd1);
            chk("t6_stall_ready", 32'(s_ready), 32'h2);
        end
        src_en[1] = 1'b1;
        drive(); run(20);
        exp_q.push_back(e(2'd1, 1'b0, 8'h71));
        exp_q.push_back(e(2'd1, 1'b0, 8'h72));
        exp_q.push_back(e(2'd1, 1'b0, 8'h73));
        exp_q.push_back(e(2'd1, 1'b1, 8'h74));
        exp_q.push_back(e(2'd3, 1'b1, 8'h81));
        check_log("t6_log");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
